// File: rtl/stage_sequencer.sv
// Pipeline stage-enable sequencer: thermometer fill, spaced issue, thermometer drain,
// with stall/flush, an instruction budget and a start/busy/done handshake.
module stage_sequencer #(
    parameter int WIDTH = 6,
    parameter int GAP   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stall,
    input  logic             flush,
    input  logic [CNT_W-1:0] max_count,
    output logic [WIDTH-1:0] inst_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] inst_count
);

    localparam int K_W = $clog2(WIDTH);
    localparam int G_W = (GAP < 2) ? 1 : $clog2(GAP + 1);
    localparam logic [K_W-1:0]   K_ONE   = K_W'(1);
    localparam logic [K_W-1:0]   K_LAST  = K_W'(WIDTH - 1);
    localparam logic [G_W-1:0]   G_ONE   = G_W'(1);
    localparam logic [G_W-1:0]   G_LAST  = G_W'(GAP);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH-1:0] ALL_ON  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN_ON,
        S_RUN_GAP,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [G_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] budget_q, budget_d;
    logic [WIDTH-1:0] en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // k ones from the MSB end
    function automatic logic [WIDTH-1:0] fill_pat(input logic [K_W-1:0] k);
        return ~(ALL_ON >> k);
    endfunction

    // k ones removed from the MSB end
    function automatic logic [WIDTH-1:0] drain_pat(input logic [K_W-1:0] k);
        return ALL_ON >> k;
    endfunction

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        budget_d = budget_q;
        en_d     = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        if (flush) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                state_d  = S_FILL;
                k_d      = K_ONE;
                budget_d = max_count;
                cnt_d    = '0;
                en_d     = fill_pat(K_ONE);
                busy_d   = 1'b1;
            end
        end else if (stall) begin
            // Everything holds, so the pending pattern is shown once stall drops.
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b1;
            case (state_q)
                S_FILL: begin
                    if (k_q == K_LAST) begin
                        state_d = S_RUN_ON;
                        cnt_d   = cnt_q + CNT_ONE;
                        en_d    = ALL_ON;
                    end else begin
                        k_d  = k_q + K_ONE;
                        en_d = fill_pat(k_q + K_ONE);
                    end
                end
                S_RUN_ON: begin
                    if (budget_q != '0 && cnt_q == budget_q) begin
                        state_d = S_DRAIN;
                        k_d     = K_ONE;
                        en_d    = drain_pat(K_ONE);
                    end else if (GAP > 0) begin
                        state_d = S_RUN_GAP;
                        gap_d   = G_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        en_d  = ALL_ON;
                    end
                end
                S_RUN_GAP: begin
                    if (gap_q == G_LAST) begin
                        state_d = S_RUN_ON;
                        cnt_d   = cnt_q + CNT_ONE;
                        en_d    = ALL_ON;
                    end else begin
                        gap_d = gap_q + G_ONE;
                    end
                end
                S_DRAIN: begin
                    if (k_q == K_LAST) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        k_d  = k_q + K_ONE;
                        en_d = drain_pat(k_q + K_ONE);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            gap_q    <= '0;
            cnt_q    <= '0;
            budget_q <= '0;
            en_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
            budget_q <= budget_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign inst_en    = en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign inst_count = cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: vector table, hand-built corner sequences and a
// randomized run against a position-based reference model.
module tb_stage_sequencer;

    localparam int W = 6;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [7:0] max_count = 8'd0;
    logic [5:0] inst_en;
    logic       busy, done;
    logic [7:0] inst_count;

    logic       start0 = 1'b0, stall0 = 1'b0, flush0 = 1'b0;
    logic [7:0] max0 = 8'd0;
    logic [5:0] inst_en0;
    logic       busy0, done0;
    logic [7:0] inst_count0;

    int total = 0;
    int bad = 0;

    stage_sequencer #(.WIDTH(W), .GAP(G), .CNT_W(8)) dut (
        .clk(clk), .clr(clr), .start(start), .stall(stall), .flush(flush),
        .max_count(max_count), .inst_en(inst_en), .busy(busy), .done(done),
        .inst_count(inst_count)
    );

    stage_sequencer #(.WIDTH(W), .GAP(0), .CNT_W(8)) dut0 (
        .clk(clk), .clr(clr), .start(start0), .stall(stall0), .flush(flush0),
        .max_count(max0), .inst_en(inst_en0), .busy(busy0), .done(done0),
        .inst_count(inst_count0)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic       st, sl, fl;
        logic [7:0] mc;
        logic [5:0] en;
        logic       bz, dn;
        logic [7:0] ct;
    } vec_t;

    vec_t tbl[19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Pattern expected at the p-th non-stalled cycle of a run; -1 once the run is over.
    function automatic int pat_at(input int p, input int b);
        int r, len, d;
        if (p < W - 1) return ((1 << (p + 1)) - 1) << (W - (p + 1));
        r   = p - (W - 1);
        len = b + (b - 1) * G;
        if (b == 0 || r < len) return (r % (G + 1) == 0) ? 63 : 0;
        d = r - len;
        if (d < W - 1) return (1 << (W - (d + 1))) - 1;
        return -1;
    endfunction

    bit m_active;
    int m_p, m_b, m_cnt, m_en;
    bit m_busy, m_done;

    task automatic model_step();
        int v;
        m_done = 1'b0;
        if (flush) begin
            m_active = 1'b0; m_en = 0; m_busy = 1'b0;
        end else if (!m_active) begin
            m_en = 0; m_busy = 1'b0;
            if (start) begin
                m_active = 1'b1; m_p = 0; m_b = int'(max_count); m_cnt = 0;
                m_en = pat_at(0, m_b); m_busy = 1'b1;
            end
        end else if (stall) begin
            m_en = 0;
        end else begin
            m_p++;
            v = pat_at(m_p, m_b);
            if (v < 0) begin
                m_active = 1'b0; m_en = 0; m_busy = 1'b0; m_done = 1'b1;
            end else begin
                m_en = v;
                if (v == 63) m_cnt = (m_cnt + 1) % 256;
            end
        end
    endtask

    initial begin
        int nbusy;
        bit ok;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd3, 6'b100000, 1'b1, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b110000, 1'b1, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b111000, 1'b1, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b111100, 1'b1, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b111110, 1'b1, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b111111, 1'b1, 1'b0, 8'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'd7, 6'b000000, 1'b1, 1'b0, 8'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b111111, 1'b1, 1'b0, 8'd2};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'd7, 6'b000000, 1'b1, 1'b0, 8'd2};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b111111, 1'b1, 1'b0, 8'd3};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b011111, 1'b1, 1'b0, 8'd3};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b001111, 1'b1, 1'b0, 8'd3};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b000111, 1'b1, 1'b0, 8'd3};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b000011, 1'b1, 1'b0, 8'd3};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b000001, 1'b1, 1'b0, 8'd3};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b000000, 1'b0, 1'b1, 8'd3};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b000000, 1'b0, 1'b0, 8'd3};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 8'd7, 6'b000000, 1'b0, 1'b0, 8'd3};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 8'd3, 6'b000000, 1'b0, 1'b0, 8'd3};

        // Reset values
        #3;
        chk("rst en", 32'(inst_en), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst cnt", 32'(inst_count), 0);
        #9 clr = 1'b1;

        // Basic run, start re-pulse ignored, start+flush in IDLE
        nbusy = 0;
        for (int i = 0; i < 19; i++) begin
            start = tbl[i].st; stall = tbl[i].sl; flush = tbl[i].fl; max_count = tbl[i].mc;
            tick();
            chk($sformatf("row%0d en", i), 32'(inst_en), 32'(tbl[i].en));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].bz));
            chk($sformatf("row%0d done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("row%0d cnt", i), 32'(inst_count), 32'(tbl[i].ct));
            if (busy) nbusy++;
        end
        chk("busy cycles B3", nbusy, 15);
        start = 1'b0; flush = 1'b0;

        // Stall for two cycles in FILL
        start = 1'b1; max_count = 8'd3; tick(); start = 1'b0;
        chk("stall fill1", 32'(inst_en), 6'b100000);
        tick();
        chk("stall fill2", 32'(inst_en), 6'b110000);
        stall = 1'b1; tick();
        chk("stall z1", 32'(inst_en), 0);
        chk("stall busy1", 32'(busy), 1);
        tick();
        chk("stall z2", 32'(inst_en), 0);
        stall = 1'b0; tick();
        chk("stall resume", 32'(inst_en), 6'b111000);
        nbusy = 5;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!busy) begin ok = 1'b1; break; end
            nbusy++;
        end
        chk("stall run ended", 32'(ok), 1);
        chk("stall busy cycles", nbusy, 17);
        chk("stall done", 32'(done), 1);
        chk("stall cnt", 32'(inst_count), 3);

        // Flush during RUN_GAP with stall also high
        start = 1'b1; max_count = 8'd3; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("pre-flush gap en", 32'(inst_en), 0);
        chk("pre-flush cnt", 32'(inst_count), 2);
        flush = 1'b1; stall = 1'b1; tick();
        flush = 1'b0; stall = 1'b0;
        chk("flush en", 32'(inst_en), 0);
        chk("flush busy", 32'(busy), 0);
        chk("flush done", 32'(done), 0);
        chk("flush cnt", 32'(inst_count), 2);
        tick();
        chk("flush no done", 32'(done), 0);
        chk("flush idle busy", 32'(busy), 0);

        // GAP=0, unlimited budget, counter wrap
        start0 = 1'b1; max0 = 8'd0; tick(); start0 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("g0 last fill", 32'(inst_en0), 6'b111110);
        for (int i = 1; i <= 260; i++) begin
            tick();
            chk($sformatf("g0 en issue%0d", i), 32'(inst_en0), 6'b111111);
            chk($sformatf("g0 cnt issue%0d", i), 32'(inst_count0), 32'(i % 256));
        end
        chk("g0 busy", 32'(busy0), 1);
        flush0 = 1'b1; tick(); flush0 = 1'b0;
        chk("g0 flushed busy", 32'(busy0), 0);
        chk("g0 flushed cnt", 32'(inst_count0), 4);

        // Async reset mid-DRAIN
        start = 1'b1; max_count = 8'd1; tick(); start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("drain1 en", 32'(inst_en), 6'b011111);
        #3 clr = 1'b0;
        #1;
        chk("clr en", 32'(inst_en), 0);
        chk("clr busy", 32'(busy), 0);
        chk("clr done", 32'(done), 0);
        chk("clr cnt", 32'(inst_count), 0);
        #2 clr = 1'b1;
        tick();
        chk("post clr idle", 32'(inst_en), 0);
        start = 1'b1; max_count = 8'd2; tick(); start = 1'b0;
        chk("post clr fill", 32'(inst_en), 6'b100000);
        chk("post clr cnt", 32'(inst_count), 0);
        chk("post clr busy", 32'(busy), 1);

        // Randomized against the reference model
        #2 clr = 1'b0;
        #2 clr = 1'b1;
        m_active = 1'b0; m_p = 0; m_b = 0; m_cnt = 0; m_en = 0; m_busy = 1'b0; m_done = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            start     = ($urandom % 6) == 0;
            stall     = ($urandom % 5) == 0;
            flush     = ($urandom % 50) == 0;
            max_count = 8'($urandom % 5);
            model_step();
            tick();
            chk($sformatf("rnd%0d en", c), 32'(inst_en), 32'(m_en));
            chk($sformatf("rnd%0d busy", c), 32'(busy), 32'(m_busy));
            chk($sformatf("rnd%0d done", c), 32'(done), 32'(m_done));
            chk($sformatf("rnd%0d cnt", c), 32'(inst_count), 32'(m_cnt));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised pipeline stage-enable sequencer that drives the per-stage enable vector of the datapath. It ramps enables up one stage per cycle (fill), issues instructions at a programmable spacing (run), and ramps down one stage per cycle (drain). It supports stall, flush, a programmable instruction budget and a start/busy/done handshake. It sits between the top-level controller and the datapath stage registers.

## Interface

- WIDTH, 6: number of pipeline stages / enable bits; must be ≥ 2.
- GAP, 1: idle cycles between issue cycles in RUN; 0 means back-to-back issue.
- CNT_W, 8: width of the instruction counter and budget.

- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- stall  in  1  freeze sequencing this cycle.
- flush  in  1  synchronous abort to IDLE.
- max_count  in  CNT_W  instruction budget, latched on accepted start; 0 = unlimited.
- inst_en  out  WIDTH  stage enables; bit WIDTH-1 = first stage.
- busy  out  1  high from the first FILL cycle through the last DRAIN cycle.
- done  out  1  one-cycle pulse on normal completion.
- inst_count  out  CNT_W  instructions issued in the current or last run.

## Operation

- All outputs are registered. Reset values: inst_en=0, busy=0, done=0, inst_count=0, state=IDLE, latched budget=0.
- States: IDLE, FILL, RUN_ON, RUN_GAP, DRAIN.
- IDLE:
  - inst_en=0, busy=0.
  - On start: latch max_count, clear inst_count, go to FILL with k=1.
- FILL: inst_en holds a thermometer of k ones from the MSB, for k=1..WIDTH-1 (e.g. 100000, 110000, …, 111110). After k=WIDTH-1, go to RUN_ON.
- RUN_ON:
  - inst_en = all ones for one cycle; inst_count increments on entry.
  - Next state, in priority order:
    - DRAIN if budget≠0 and inst_count==budget.
    - Otherwise RUN_GAP if GAP>0.
    - Otherwise RUN_ON.
- RUN_GAP: inst_en=0 for GAP cycles, then RUN_ON.
- DRAIN: the thermometer empties from the MSB, one bit per cycle: 011111, 001111, …, 000001 (WIDTH-1 cycles). It then returns to IDLE with done=1 for that first IDLE cycle.
- stall:
  - While high outside IDLE, inst_en=0 and state, k, gap counter and inst_count are frozen.
  - On release, the interrupted pattern is re-presented for its full length.
  - stall is ignored in IDLE.
- flush:
  - Overrides stall and start.
  - Next cycle: IDLE, inst_en=0, busy=0, done=0. inst_count keeps its value.
- start while busy is ignored; the budget is not re-latched.
- Budget 0: run is unbounded; inst_count wraps modulo 2^CNT_W without leaving RUN.
- Async reset asserted at any time forces the reset values immediately, regardless of clk.

## Timing

- start high at edge N (IDLE) → inst_en=100…0 and busy=1 after edge N.
- First all-ones issue WIDTH-1 cycles after that.
- Issue period in RUN is GAP+1 cycles.
- Last RUN_ON → first DRAIN pattern at the next edge, with no gap cycle inserted.
- Last DRAIN pattern → done=1, busy=0, inst_en=0 at the next edge; done clears one cycle later.
- Total cycles busy for budget B (no stalls) = 2(WIDTH-1) + B + (B-1)·GAP.
- flush or stall at edge N takes effect in the outputs after edge N.
- clr deassertion takes effect at the first rising edge after release.

## Test plan

- WIDTH=6, GAP=1, max_count=3, pulse start → inst_en sequence: 100000, 110000, 111000, 111100, 111110, 111111, 000000, 111111, 000000, 111111, 011111, 001111, 000111, 000011, 000001, 000000. done pulses on the final 000000; inst_count=3; busy high for exactly 15 cycles.
- Same run with stall high for 2 cycles while inst_en=111000 → two cycles of 000000, then 111000 re-presented and the sequence continues; busy count=17.
- flush asserted during a RUN_GAP cycle with stall also high → next cycle IDLE, inst_en=0, busy=0, no done pulse, inst_count holds its value (e.g. 2).
- GAP=0, max_count=0, CNT_W=8, run 260 issue cycles → inst_en stays 111111 continuously after fill; inst_count wraps 255→0 and reads 4 after the 260th issue.
- clr driven low mid-DRAIN between clock edges → all outputs 0 immediately. After release and a new start, FILL restarts at 100000 with inst_count=0.
- start re-pulsed during RUN with a different max_count → ignored; run ends at the original budget. start and flush together in IDLE → remains IDLE.
